fp_op_arbiter: RTL and testbench

FP_OP_ARBITER -- requirements
Module: fp_op_arbiter

---
 rtl/fp_op_arbiter_pkg.sv | 7 +
 rtl/rr_grant2.sv | 16 +
 rtl/fp_op_arbiter.sv | 93 +++++++++
 tb/tb_fp_op_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_op_arbiter_pkg.sv
// fp_op_arbiter_pkg: shared op encodings, default unit latencies and float word width
package fp_op_arbiter_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_e;
  localparam int MUL_LAT_DEF = 9;
  localparam int ADD_LAT_DEF = 14;
  localparam int FW = 32;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-requester round-robin grant whose pointer only moves on contention
module rr_grant2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] el,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt = &el ? {ptr_q, ~ptr_q} : el;
    ptr_d = &el ? ~ptr_q : ptr_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/fp_op_arbiter.sv
// fp_op_arbiter: shares one FP adder and one FP multiplier between two requesters
module fp_op_arbiter
  import fp_op_arbiter_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_op,
  input  logic [1:0][FW-1:0] req_a,
  input  logic [1:0][FW-1:0] req_b,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [1:0][FW-1:0] rsp_data,
  output logic [FW-1:0]      mul_a,
  output logic [FW-1:0]      mul_b,
  input  logic [FW-1:0]      mul_result,
  output logic [FW-1:0]      add_a,
  output logic [FW-1:0]      add_b,
  input  logic [FW-1:0]      add_result
);
  logic en_q;
  logic [1:0] busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [1:0] el_add, el_mul, g_add, g_mul, a_hit, m_hit;
  logic [1:0][FW-1:0] rsp_data_q, rsp_data_d;
  logic [FW-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, add_a_q, add_a_d, add_b_q, add_b_d;
  logic [MUL_LAT:0] mv_q, mv_d, mid_q, mid_d;
  logic [ADD_LAT:0] av_q, av_d, aid_q, aid_d;
  always_comb begin
    el_add = '0;
    el_mul = '0;
    for (int i = 0; i < 2; i++) begin
      el_add[i] = en_q && req_valid[i] && !busy_q[i] && op_e'(req_op[i]) == OP_ADD;
      el_mul[i] = en_q && req_valid[i] && !busy_q[i] && op_e'(req_op[i]) == OP_MUL;
    end
  end
  rr_grant2 u_add_rr (.clk(clk), .rst(rst), .el(el_add), .gnt(g_add));
  rr_grant2 u_mul_rr (.clk(clk), .rst(rst), .el(el_mul), .gnt(g_mul));
  assign req_ready = g_add | g_mul;
  always_comb begin
    add_a_d = |g_add ? req_a[g_add[1]] : add_a_q;
    add_b_d = |g_add ? req_b[g_add[1]] : add_b_q;
    mul_a_d = |g_mul ? req_a[g_mul[1]] : mul_a_q;
    mul_b_d = |g_mul ? req_b[g_mul[1]] : mul_b_q;
    av_d = {av_q[ADD_LAT-1:0], |g_add};
    aid_d = {aid_q[ADD_LAT-1:0], g_add[1]};
    mv_d = {mv_q[MUL_LAT-1:0], |g_mul};
    mid_d = {mid_q[MUL_LAT-1:0], g_mul[1]};
    a_hit = {2{av_q[ADD_LAT]}} & {aid_q[ADD_LAT], ~aid_q[ADD_LAT]};
    m_hit = {2{mv_q[MUL_LAT]}} & {mid_q[MUL_LAT], ~mid_q[MUL_LAT]};
    rsp_valid_d = a_hit | m_hit;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < 2; i++)
      rsp_data_d[i] = a_hit[i] ? add_result : m_hit[i] ? mul_result : rsp_data_q[i];
    busy_d = (busy_q | req_ready) & ~rsp_valid_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_q <= 1'b0;
      busy_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      mv_q <= '0;
      mid_q <= '0;
      av_q <= '0;
      aid_q <= '0;
    end else begin
      en_q <= 1'b1;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      mv_q <= mv_d;
      mid_q <= mid_d;
      av_q <= av_d;
      aid_q <= aid_d;
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
endmodule

// File: tb/tb_fp_op_arbiter.sv
// tb_fp_op_arbiter: table, directed and random checks of fp_op_arbiter against a transaction-level model
module tb_fp_op_arbiter;
  localparam int ML = 9;
  localparam int AL = 14;
  typedef struct {
    bit id;
    bit op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req_valid = '0, req_op = '0, req_ready, rsp_valid;
  logic [1:0][31:0] req_a = '0, req_b = '0, rsp_data;
  logic [31:0] mul_a, mul_b, mul_result, add_a, add_b, add_result;
  logic [31:0] mp [ML];
  logic [31:0] ap [AL];
  int checks = 0, errors = 0, cyc = 0, scyc = 0;
  logic [1:0] s_rdy, s_rv;
  bit busy [2];
  bit ptr [2];
  int done [2];
  int ng [2];
  int nrsp [2];
  logic [31:0] expd [2];
  vec_t tbl [5];
  always #5 clk = ~clk;
  fp_op_arbiter #(.MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .add_a(add_a), .add_b(add_b), .add_result(add_result)
  );
  function automatic real s2r(logic [31:0] s);
    if (s[30:0] == 31'd0) return 0.0;
    return $bitstoreal({s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] fop(bit m, logic [31:0] x, logic [31:0] y);
    return r2s(m ? s2r(x) * s2r(y) : s2r(x) + s2r(y));
  endfunction
  function automatic logic [31:0] rv();
    real r;
    r = real'($urandom_range(1, 16)) / 2.0;
    return r2s($urandom_range(0, 1) != 0 ? -r : r);
  endfunction
  always @(posedge clk) begin
    mp[0] <= fop(1'b1, mul_a, mul_b);
    ap[0] <= fop(1'b0, add_a, add_b);
    for (int k = 1; k < ML; k++) mp[k] <= mp[k-1];
    for (int k = 1; k < AL; k++) ap[k] <= ap[k-1];
  end
  assign mul_result = mp[ML-1];
  assign add_result = ap[AL-1];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic step();
    logic [1:0] ev, er, c;
    #1;
    scyc = cyc;
    s_rdy = req_ready;
    s_rv = rsp_valid;
    for (int i = 0; i < 2; i++) ev[i] = busy[i] && done[i] == cyc;
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) check("rsp_data", rsp_data[i], expd[i]);
      if (rsp_valid[i]) nrsp[i]++;
    end
    er = '0;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 2; i++) c[i] = req_valid[i] && !busy[i] && int'(req_op[i]) == u;
      if (&c) begin
        er[ptr[u]] = 1'b1;
        ptr[u] = !ptr[u];
      end else er = er | c;
    end
    check("req_ready", 32'(req_ready), 32'(er));
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) busy[i] = 1'b0;
      if (er[i]) begin
        busy[i] = 1'b1;
        done[i] = cyc + (req_op[i] ? ML : AL) + 2;
        expd[i] = fop(req_op[i], req_a[i], req_b[i]);
        ng[i]++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic rst_seq(input int n);
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data[0] | rsp_data[1], 32'd0);
    check("rst_operands", mul_a | mul_b | add_a | add_b, 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (busy[i]) ng[i]--;
      busy[i] = 1'b0;
      ptr[i] = 1'b0;
    end
    repeat (n) @(negedge clk);
    cyc += n;
    rst = 1'b1;
    req_valid = 2'b11;
    req_op = 2'b00;
    #1;
    check("release_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    cyc++;
    req_valid = '0;
  endtask
  task automatic pair(input logic [1:0] ops, output int h0, output int h1, output int r0, output int r1);
    h0 = -1; h1 = -1; r0 = -1; r1 = -1;
    req_valid = 2'b11;
    req_op = ops;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = rv();
      req_b[i] = rv();
    end
    for (int t = 0; t < 60 && (r0 < 0 || r1 < 0); t++) begin
      step();
      if (h0 < 0 && s_rdy[0]) begin h0 = scyc; req_valid[0] = 1'b0; end
      if (h1 < 0 && s_rdy[1]) begin h1 = scyc; req_valid[1] = 1'b0; end
      if (s_rv[0]) r0 = scyc;
      if (s_rv[1]) r1 = scyc;
    end
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog");
  end
  initial begin
    int h, r, h0, h1, r0, r1, g, n0, n1;
    bit last;
    tbl[0] = '{1'b0, 1'b1, 32'h40000000, 32'h40400000, 32'h40C00000, 11};
    tbl[1] = '{1'b1, 1'b0, 32'h3FC00000, 32'h40200000, 32'h40800000, 16};
    tbl[2] = '{1'b1, 1'b1, 32'h40800000, 32'h3F000000, 32'h40000000, 11};
    tbl[3] = '{1'b0, 1'b0, 32'hBF800000, 32'h40400000, 32'h40000000, 16};
    tbl[4] = '{1'b0, 1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 16};
    @(negedge clk);
    rst_seq(3);
    for (int v = 0; v < 5; v++) begin
      h = -1;
      r = -1;
      req_valid[tbl[v].id] = 1'b1;
      req_op[tbl[v].id] = tbl[v].op;
      req_a[tbl[v].id] = tbl[v].a;
      req_b[tbl[v].id] = tbl[v].b;
      for (int t = 0; t < 40 && r < 0; t++) begin
        step();
        if (h < 0 && s_rdy[tbl[v].id]) begin h = scyc; req_valid[tbl[v].id] = 1'b0; end
        if (s_rv[tbl[v].id]) r = scyc;
      end
      check("tbl_latency", 32'(r - h), 32'(tbl[v].lat));
      check("tbl_data", rsp_data[tbl[v].id], tbl[v].res);
      step();
    end
    pair(2'b00, h0, h1, r0, r1);
    check("add_pair_r0_latency", 32'(r0 - h0), 32'(AL + 2));
    check("add_pair_grant_gap", 32'(h1 - h0), 32'd1);
    check("add_pair_rsp_gap", 32'(r1 - r0), 32'd1);
    pair(2'b10, h0, h1, r0, r1);
    check("mix_same_cycle", 32'(h1 - h0), 32'd0);
    check("mix_rsp_gap", 32'(r0 - r1), 32'd5);
    h = -1;
    r = -1;
    req_valid = 2'b01;
    req_op = 2'b00;
    req_a[0] = rv();
    req_b[0] = rv();
    for (int t = 0; t < 40 && r < 0; t++) begin
      step();
      if (h < 0 && s_rdy[0]) h = scyc;
      else if (h >= 0 && s_rv[0]) r = scyc;
    end
    check("hold_rsp_seen", 32'(r >= 0), 32'd1);
    step();
    check("hold_ready_after_rsp", 32'(s_rdy[0]), 32'd1);
    req_valid = '0;
    repeat (20) step();
    n0 = nrsp[0];
    n1 = nrsp[1];
    g = 0;
    last = 1'b0;
    req_valid = 2'b11;
    req_op = 2'b00;
    for (int t = 0; t < 400 && g < 20; t++) begin
      req_a[t % 2] = rv();
      req_b[t % 2] = rv();
      step();
      for (int i = 0; i < 2; i++)
        if (s_rdy[i]) begin
          if (g > 0) check("stream_alternation", 32'(i), 32'(!last));
          last = i[0];
          g++;
        end
      if (g >= 20) req_valid = '0;
    end
    repeat (20) step();
    check("stream_grants", 32'(g), 32'd20);
    check("stream_r0_results", 32'(nrsp[0] - n0), 32'd10);
    check("stream_r1_results", 32'(nrsp[1] - n1), 32'd10);
    h = -1;
    req_valid = 2'b01;
    req_op = 2'b01;
    req_a[0] = rv();
    req_b[0] = rv();
    for (int t = 0; t < 10 && h < 0; t++) begin
      step();
      if (s_rdy[0]) begin h = scyc; req_valid[0] = 1'b0; end
    end
    check("rst_mul_accepted", 32'(h >= 0), 32'd1);
    repeat (4) step();
    rst_seq(3);
    req_valid = 2'b01;
    req_op = 2'b00;
    step();
    check("ready_first_edge_after_release", 32'(s_rdy[0]), 32'd1);
    req_valid = '0;
    repeat (30) step();
    for (int t = 0; t < 1500; t++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_op = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_a[i] = rv();
        req_b[i] = rv();
      end
      step();
    end
    req_valid = '0;
    repeat (25) step();
    check("no_lost_r0", 32'(nrsp[0]), 32'(ng[0]));
    check("no_lost_r1", 32'(nrsp[1]), 32'(ng[1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
